// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, default width and bit-counter sizing.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} sa_state_t;
  localparam int SA_DEFAULT_WIDTH = 8;
  function automatic int sa_cnt_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result valid-ready bundle; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if import serial_adder_pkg::*; #(parameter int WIDTH = SA_DEFAULT_WIDTH);
  logic in_valid, in_ready, ci, out_valid, out_ready, co;
  logic [WIDTH-1:0] a, b, s;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
  modport master (output in_valid, a, b, ci, out_ready, input in_ready, out_valid, s, co, ovf);
  modport slave (input in_valid, a, b, ci, out_ready, output in_ready, out_valid, s, co, ovf);
`else
  modport master (output in_valid, a, b, ci, out_ready, input in_ready, out_valid, s, co);
  modport slave (input in_valid, a, b, ci, out_ready, output in_ready, out_valid, s, co);
`endif
endinterface

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: combinational one-bit full adder cell.
module fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder around one fa_bit cell and a carry flop.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave sa
);
  localparam int CW = sa_cnt_w(WIDTH);
  sa_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, s_shift;
  logic c_q, c_d, co_q, co_d, fs, fc, take, busy, last;
  fa_bit u_fa (.a_i(a_q[0]), .b_i(b_q[0]), .ci_i(c_q), .s_o(fs), .co_o(fc));
  assign take = state_q == IDLE && sa.in_valid;
  assign busy = state_q == BUSY;
  assign last = cnt_q == CW'(WIDTH - 1);
  generate
    if (WIDTH == 1) begin : g_one
      assign s_shift = fs;
    end else begin : g_many
      assign s_shift = {fs, s_q[WIDTH-1:1]};
    end
  endgenerate
  always_comb begin
    state_d = state_q == IDLE ? (sa.in_valid ? BUSY : IDLE) :
              state_q == BUSY ? (last ? DONE : BUSY) :
              state_q == DONE && !sa.out_ready ? DONE : IDLE;
    cnt_d = take ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
    a_d = take ? sa.a : busy ? a_q >> 1 : a_q;
    b_d = take ? sa.b : busy ? b_q >> 1 : b_q;
    c_d = take ? sa.ci : busy ? fc : c_q;
    s_d = busy ? s_shift : s_q;
    co_d = busy && last ? fc : co_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= 1'b0;
      co_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      co_q <= co_d;
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  // on the last bit c_q is the carry into the MSB and fc the carry out of it
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (busy && last) ovf_q <= c_q ^ fc;
  end
  assign sa.ovf = ovf_q;
`endif
  assign sa.in_ready = state_q == IDLE;
  assign sa.out_valid = state_q == DONE;
  assign sa.s = s_q;
  assign sa.co = co_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell plus a carry flop.
- Accepts operands a, b and carry-in ci over a valid/ready handshake.
- Processes one bit per clock, LSB first.
- Returns the sum s and carry-out co over a valid/ready handshake.
- Serves as the sequential datapath stage that consumes the chapter-3 one-bit adder cell; it is the area-minimal alternative to a ripple array.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk
in_valid  input  1  operands a/b/ci are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  addend
b  input  WIDTH  addend
ci  input  1  carry-in
out_valid  output  1  s/co are valid
out_ready  input  1  consumer accepts result
s  output  WIDTH  sum, equal to (a+b+ci) mod 2^WIDTH
co  output  1  carry-out, equal to bit WIDTH of a+b+ci

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, BUSY, DONE.
- Reset (rst=1 at a clk edge) forces the following, regardless of current state, including mid-BUSY:
  - state=IDLE, bit counter=0, carry flop=0;
  - operand shift registers=0, s=0, co=0, out_valid=0;
  - in_ready=1 in the first cycle after reset release.
- Outputs are decoded from state: in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - When in_valid&&in_ready, capture a and b into shift registers, ci into the carry flop, clear the counter, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each cycle, the full-adder cell computes sum/carry from the register LSBs and the carry flop.
  - The sum bit shifts into the MSB of the s register (right shift).
  - a/b registers shift right; the carry flop takes the cell's carry out.
  - The counter increments.
  - After exactly WIDTH BUSY cycles (counter==WIDTH-1 at the edge), load co from the final carry and go to DONE.
- DONE:
  - s and co are held stable while out_valid=1.
  - When out_ready=1, go to IDLE on that edge. The next operand can therefore be accepted no earlier than the following cycle; there is no DONE->BUSY bypass.
- Latency: accepting edge to out_valid is WIDTH+1 edges. Throughput is one result per WIDTH+2 cycles when out_ready is held at 1.
- in_valid while BUSY or DONE is ignored; operands are not captured and the upstream stage must hold them.
- out_ready while not in DONE has no effect.
- WIDTH=1 degenerates to a single BUSY cycle with identical handshake behaviour.
- s retains the last result after leaving DONE until the next BUSY overwrites it; consumers must sample it only while out_valid=1.
- Counter width is $clog2(WIDTH) with a minimum of 1 bit. No arithmetic wider than WIDTH except co.

Optional Feature:
SERIAL_ADDER_OVF_EN:
- When defined, adds output port ovf (1 bit): signed two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.
  - Captured on the same edge as co, valid with out_valid, and reset to 0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum type sa_state_t {IDLE, BUSY, DONE} (2 bits);
  - localparam SA_DEFAULT_WIDTH=8.
- Sub-module fa_bit is a natural split: a purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once inside serial_adder.

Test Plan:
- WIDTH=8: a=0xFF, b=0x01, ci=0, out_ready=1 -> out_valid rises 9 edges after acceptance; s=0x00, co=1.
- WIDTH=8: a=0x5A, b=0x25, ci=1 -> s=0x80, co=0; with SERIAL_ADDER_OVF_EN, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> s/co stable, in_ready=0, and a second in_valid pulse is ignored. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Reset mid-operation: assert rst at the 4th BUSY cycle of 0x0F+0xF0 -> next cycle state=IDLE, out_valid=0, s=0, co=0. A fresh 0x01+0x01+0 then gives s=0x02, co=0.
- WIDTH=3 exhaustive: all 128 {a,b,ci} combinations compared against a+b+ci -> zero mismatches. Back-to-back transactions with in_valid held high are each accepted exactly once.
- WIDTH=1: a=1, b=1, ci=1 -> s=1, co=1 after 2 edges.
